// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM for the ALU/datapath: fetch, decode, execute,
// memory access and write-back sequencing with a memory-handshake timeout trap.
module alu_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_sign,
   input  logic       i_mem_ready,
   output logic [2:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic       o_shamt_sel,
   output logic       o_ir_write,
   output logic       o_pc_write,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_reg_write,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
   output logic [1:0] o_pc_src,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLTZ = 6'h01, OP_J     = 6'h02,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                          OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
                          OP_LW    = 6'h23, OP_SW   = 6'h2B;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_WB_ALU   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_WB_MEM   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_op;
   logic [5:0]       r_funct;
   logic             r_illegal;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       w_rdec;
   logic [4:0]       w_idec;
   logic             w_wait;
   logic             w_tmo;
   logic             w_taken;

   // R-type funct -> {legal, alu_op}
   function automatic logic [3:0] f_rdecode(input logic [5:0] fn);
      case (fn)
         6'h20, 6'h21: f_rdecode = {1'b1, 3'b000};
         6'h22, 6'h23: f_rdecode = {1'b1, 3'b001};
         6'h24:        f_rdecode = {1'b1, 3'b110};
         6'h25:        f_rdecode = {1'b1, 3'b101};
         6'h26:        f_rdecode = {1'b1, 3'b111};
         6'h2A:        f_rdecode = {1'b1, 3'b011};
         6'h2B:        f_rdecode = {1'b1, 3'b010};
         6'h00:        f_rdecode = {1'b1, 3'b100};
         default:      f_rdecode = {1'b0, 3'b000};
      endcase
   endfunction

   // I-type opcode -> {alu_op, alu_src_b}; logical ops use zero-extended immediates
   function automatic logic [4:0] f_idecode(input logic [5:0] op);
      case (op)
         OP_SLTI:  f_idecode = {3'b011, 2'b10};
         OP_SLTIU: f_idecode = {3'b010, 2'b10};
         OP_ANDI:  f_idecode = {3'b110, 2'b11};
         OP_ORI:   f_idecode = {3'b101, 2'b11};
         OP_XORI:  f_idecode = {3'b111, 2'b11};
         default:  f_idecode = {3'b000, 2'b10};
      endcase
   endfunction

   // State, sticky trap flag and wait-state timeout counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) r_illegal <= 1'b1;
         // any state change restarts the count, which covers every entry into a wait state
         if (w_next != r_state) r_cnt <= '0;
         else if (w_wait && !i_mem_ready) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Capture the instruction class/op at DECODE for the later states
   always_ff @(posedge i_clk) begin
      if (r_state == S_DECODE) begin
         r_op    <= i_opcode;
         r_funct <= i_funct;
      end
   end

   // Next-state decode and Moore outputs; everything is held low during reset
   always_comb begin
      w_next       = r_state;
      w_rdec       = f_rdecode(r_funct);
      w_idec       = f_idecode(r_op);
      w_wait       = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
      w_tmo        = (MEM_TIMEOUT != 0) && w_wait && !i_mem_ready && (r_cnt == LIMIT);
      w_taken      = ((r_op == OP_BEQ) && i_zero) || ((r_op == OP_BNE) && !i_zero) ||
                     ((r_op == OP_BLTZ) && i_sign);
      o_alu_op     = 3'b000;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_shamt_sel  = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_reg_write  = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_pc_src     = 2'b00;
      o_illegal    = r_illegal;
      o_state      = r_state;
      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            if (i_mem_ready) begin
               o_ir_write = 1'b1;
               o_pc_write = 1'b1;
               w_next     = S_DECODE;
            end else if (w_tmo) begin
               w_next = S_TRAP;
            end
         end
         S_DECODE: begin
            o_alu_src_b = 2'b10;
            case (i_opcode)
               OP_RTYPE:                            w_next = S_EXEC_R;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
               OP_ANDI, OP_ORI, OP_XORI:            w_next = S_EXEC_I;
               OP_LW, OP_SW:                        w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BLTZ:             w_next = S_BRANCH;
               OP_J:                                w_next = S_JUMP;
               default:                             w_next = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = w_rdec[2:0];
            o_shamt_sel = (r_funct == 6'h00);
            w_next      = w_rdec[3] ? S_WB_ALU : S_TRAP;
         end
         S_EXEC_I: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = w_idec[4:2];
            o_alu_src_b = w_idec[1:0];
            w_next      = S_WB_ALU;
         end
         S_WB_ALU: begin
            o_reg_write = 1'b1;
            o_reg_dst   = (r_op == OP_RTYPE);
            w_next      = S_FETCH;
         end
         S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            w_next      = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            o_mem_read = 1'b1;
            if (i_mem_ready) w_next = S_WB_MEM;
            else if (w_tmo)  w_next = S_TRAP;
         end
         S_WB_MEM: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_WR: begin
            o_mem_write = 1'b1;
            if (i_mem_ready) w_next = S_FETCH;
            else if (w_tmo)  w_next = S_TRAP;
         end
         S_BRANCH: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = 3'b001;
            o_pc_src    = 2'b01;
            o_pc_write  = w_taken;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            o_pc_src   = 2'b10;
            o_pc_write = 1'b1;
            w_next     = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_TRAP;
      endcase
      if (i_rst) begin
         o_alu_op     = 3'b000;
         o_alu_src_a  = 1'b0;
         o_alu_src_b  = 2'b00;
         o_shamt_sel  = 1'b0;
         o_ir_write   = 1'b0;
         o_pc_write   = 1'b0;
         o_mem_read   = 1'b0;
         o_mem_write  = 1'b0;
         o_reg_write  = 1'b0;
         o_reg_dst    = 1'b0;
         o_mem_to_reg = 1'b0;
         o_pc_src     = 2'b00;
         o_illegal    = 1'b0;
         o_state      = 4'd0;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: table-driven instruction vectors, hand-written
// multi-cycle corner cases and a randomized instruction stream, all checked
// cycle by cycle against an instruction-level reference model.
module tb_alu_ctrl_fsm;

   localparam int TMO = 4;

   localparam logic [5:0] OP_R = 6'h00, OP_BLTZ = 6'h01, OP_J = 6'h02, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                          OP_LW = 6'h23, OP_SW = 6'h2B;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       shamt;
      logic       ir_w;
      logic       pc_w;
      logic       mr;
      logic       mw;
      logic       rw;
      logic       rdst;
      logic       m2r;
      logic [1:0] pc_src;
      logic       ill;
   } out_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       s;
      logic [2:0] x_op;
      logic [1:0] x_srcb;
      int         x_lat;
      logic       x_rw;
      logic       x_pcw;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [5:0] i_opcode = '0;
   logic [5:0] i_funct = '0;
   logic       i_zero = 1'b0;
   logic       i_sign = 1'b0;
   logic       i_mem_ready = 1'b0;
   logic [2:0] o_alu_op;
   logic       o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic       o_shamt_sel, o_ir_write, o_pc_write, o_mem_read, o_mem_write;
   logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal;
   logic [1:0] o_pc_src;
   logic [3:0] o_state;

   int   total = 0;
   int   bad = 0;
   out_t obs[$];
   out_t m_all;
   out_t m_strobe;

   alu_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct(i_funct),
      .i_zero(i_zero), .i_sign(i_sign), .i_mem_ready(i_mem_ready),
      .o_alu_op(o_alu_op), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
      .o_shamt_sel(o_shamt_sel), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
      .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg), .o_pc_src(o_pc_src),
      .o_illegal(o_illegal), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- reference model: instruction-level rules ----------------
   function automatic logic r_legal(input logic [5:0] fn);
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00};
   endfunction

   function automatic logic [2:0] r_aluop(input logic [5:0] fn);
      case (fn)
         6'h22, 6'h23: return 3'b001;
         6'h24:        return 3'b110;
         6'h25:        return 3'b101;
         6'h26:        return 3'b111;
         6'h2A:        return 3'b011;
         6'h2B:        return 3'b010;
         6'h00:        return 3'b100;
         default:      return 3'b000;
      endcase
   endfunction

   function automatic logic is_itype(input logic [5:0] op);
      return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
   endfunction

   function automatic logic [2:0] i_aluop(input logic [5:0] op);
      case (op)
         OP_SLTI:  return 3'b011;
         OP_SLTIU: return 3'b010;
         OP_ANDI:  return 3'b110;
         OP_ORI:   return 3'b101;
         OP_XORI:  return 3'b111;
         default:  return 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] i_srcb(input logic [5:0] op);
      return (op inside {OP_ANDI, OP_ORI, OP_XORI}) ? 2'b11 : 2'b10;
   endfunction

   function automatic out_t sample();
      out_t a;
      a.alu_op = o_alu_op;   a.src_a = o_alu_src_a;  a.src_b = o_alu_src_b;
      a.shamt  = o_shamt_sel; a.ir_w = o_ir_write;   a.pc_w  = o_pc_write;
      a.mr     = o_mem_read; a.mw    = o_mem_write;  a.rw    = o_reg_write;
      a.rdst   = o_reg_dst;  a.m2r   = o_mem_to_reg; a.pc_src = o_pc_src;
      a.ill    = o_illegal;
      return a;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   // one clock: drive inputs after the falling edge, check settled outputs
   task automatic cyc(input out_t exp, input out_t msk, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic s, input string nm);
      out_t act;
      @(negedge i_clk);
      i_rst = 1'b0; i_mem_ready = rdy; i_opcode = op; i_funct = fn; i_zero = z; i_sign = s;
      #1;
      act = sample();
      total++;
      if ((act & msk) !== (exp & msk)) begin
         bad++;
         $display("FAIL %s op=%02h fn=%02h: got=%05h want=%05h (mask %05h)", nm, op, fn, act, exp, msk);
      end
      obs.push_back(act);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1; i_mem_ready = rb(); i_opcode = r6(); i_funct = r6(); i_zero = rb(); i_sign = rb();
      #1;
      total++;
      if ({sample(), o_state} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got=%05h state=%0d want all zero", sample(), o_state);
      end
   endtask

   task automatic trap_seq(input logic [5:0] op, input logic [5:0] fn);
      out_t e;
      for (int k = 0; k < 3; k++) begin
         e = '0; e.ill = 1'b1;
         cyc(e, m_all, rb(), r6(), r6(), rb(), rb(), "trap");
      end
      do_reset();
   endtask

   // wait phase of a memory handshake; returns 1 when the model predicts a timeout trap
   task automatic wait_phase(input out_t e, input int nwait, input logic [5:0] op,
                             input logic [5:0] fn, input string nm, output logic trapped);
      int nlow;
      nlow = (nwait < TMO) ? nwait : TMO;
      for (int i = 0; i < nlow; i++) cyc(e, m_all, 1'b0, op, fn, rb(), rb(), nm);
      trapped = (nwait >= TMO);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic s, input int fw, input int mw);
      out_t e;
      logic tr;
      obs.delete();
      e = '0; e.mr = 1'b1; e.src_b = 2'b01;
      wait_phase(e, fw, r6(), r6(), "fetch_wait", tr);
      if (tr) begin trap_seq(op, fn); return; end
      e.ir_w = 1'b1; e.pc_w = 1'b1;
      cyc(e, m_all, 1'b1, r6(), r6(), rb(), rb(), "fetch");
      e = '0; e.src_b = 2'b10;
      cyc(e, m_all, rb(), op, fn, rb(), rb(), "decode");
      if (op == OP_R) begin
         if (!r_legal(fn)) begin
            e = '0;
            cyc(e, m_strobe, rb(), op, fn, rb(), rb(), "exec_r_badfunct");
            trap_seq(op, fn);
            return;
         end
         e = '0; e.src_a = 1'b1; e.alu_op = r_aluop(fn); e.shamt = (fn == 6'h00);
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "exec_r");
         e = '0; e.rw = 1'b1; e.rdst = 1'b1;
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "wb_r");
      end else if (is_itype(op)) begin
         e = '0; e.src_a = 1'b1; e.alu_op = i_aluop(op); e.src_b = i_srcb(op);
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "exec_i");
         e = '0; e.rw = 1'b1;
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "wb_i");
      end else if (op == OP_LW || op == OP_SW) begin
         e = '0; e.src_a = 1'b1; e.src_b = 2'b10;
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "mem_addr");
         e = '0;
         if (op == OP_LW) e.mr = 1'b1; else e.mw = 1'b1;
         wait_phase(e, mw, op, fn, "mem_wait", tr);
         if (tr) begin trap_seq(op, fn); return; end
         cyc(e, m_all, 1'b1, op, fn, rb(), rb(), "mem_done");
         if (op == OP_LW) begin
            e = '0; e.rw = 1'b1; e.m2r = 1'b1;
            cyc(e, m_all, rb(), op, fn, rb(), rb(), "wb_mem");
         end
      end else if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ) begin
         e = '0; e.src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01;
         e.pc_w = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
         cyc(e, m_all, rb(), op, fn, z, s, "branch");
      end else if (op == OP_J) begin
         e = '0; e.pc_src = 2'b10; e.pc_w = 1'b1;
         cyc(e, m_all, rb(), op, fn, rb(), rb(), "jump");
      end else begin
         trap_seq(op, fn);
      end
   endtask

   task automatic check(input logic cond, input string nm, input int got, input int want);
      total++;
      if (!cond) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", nm, got, want);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t       tbl[$];
      logic       any_rw;
      logic [5:0] legal_ops[14];
      logic [5:0] legal_fn[10];
      logic [5:0] op, fn;
      int         fw, mw;

      m_all = '1;
      m_strobe = '0;
      m_strobe.ir_w = 1'b1; m_strobe.pc_w = 1'b1; m_strobe.mr = 1'b1;
      m_strobe.mw = 1'b1; m_strobe.rw = 1'b1; m_strobe.ill = 1'b1;

      legal_ops = '{OP_R, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
                    OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J};
      legal_fn  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00};

      //            op        fn     z     s     x_op    x_srcb lat rw    pcw
      tbl.push_back('{OP_R,    6'h20, 1'b0, 1'b0, 3'b000, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_R,    6'h22, 1'b0, 1'b0, 3'b001, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_R,    6'h00, 1'b0, 1'b0, 3'b100, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_R,    6'h2A, 1'b0, 1'b0, 3'b011, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_R,    6'h2B, 1'b0, 1'b0, 3'b010, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_R,    6'h26, 1'b0, 1'b0, 3'b111, 2'b00, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_ORI,  6'h11, 1'b0, 1'b0, 3'b101, 2'b11, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_SLTI, 6'h11, 1'b0, 1'b0, 3'b011, 2'b10, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_ANDI, 6'h11, 1'b0, 1'b0, 3'b110, 2'b11, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_SLTIU,6'h11, 1'b0, 1'b0, 3'b010, 2'b10, 4, 1'b1, 1'b0});
      tbl.push_back('{OP_LW,   6'h11, 1'b0, 1'b0, 3'b000, 2'b10, 5, 1'b1, 1'b0});
      tbl.push_back('{OP_SW,   6'h11, 1'b0, 1'b0, 3'b000, 2'b10, 4, 1'b0, 1'b0});
      tbl.push_back('{OP_BEQ,  6'h11, 1'b1, 1'b0, 3'b001, 2'b00, 3, 1'b0, 1'b1});
      tbl.push_back('{OP_BEQ,  6'h11, 1'b0, 1'b0, 3'b001, 2'b00, 3, 1'b0, 1'b0});
      tbl.push_back('{OP_BNE,  6'h11, 1'b0, 1'b1, 3'b001, 2'b00, 3, 1'b0, 1'b1});
      tbl.push_back('{OP_BLTZ, 6'h11, 1'b0, 1'b1, 3'b001, 2'b00, 3, 1'b0, 1'b1});
      tbl.push_back('{OP_BLTZ, 6'h11, 1'b1, 1'b0, 3'b001, 2'b00, 3, 1'b0, 1'b0});
      tbl.push_back('{OP_J,    6'h11, 1'b0, 1'b0, 3'b000, 2'b00, 3, 1'b0, 1'b1});

      do_reset();

      foreach (tbl[k]) begin
         run_instr(tbl[k].op, tbl[k].fn, tbl[k].z, tbl[k].s, 0, 0);
         any_rw = 1'b0;
         foreach (obs[j]) any_rw |= obs[j].rw;
         total++;
         if (obs.size() != tbl[k].x_lat || obs[2].alu_op !== tbl[k].x_op ||
             obs[2].src_b !== tbl[k].x_srcb || any_rw !== tbl[k].x_rw ||
             obs[obs.size()-1].pc_w !== tbl[k].x_pcw) begin
            bad++;
            $display("FAIL vec%0d op=%02h: lat=%0d aluop=%0d srcb=%0d rw=%0d pcw=%0d want lat=%0d aluop=%0d srcb=%0d rw=%0d pcw=%0d",
                     k, tbl[k].op, obs.size(), obs[2].alu_op, obs[2].src_b, any_rw,
                     obs[obs.size()-1].pc_w, tbl[k].x_lat, tbl[k].x_op, tbl[k].x_srcb,
                     tbl[k].x_rw, tbl[k].x_pcw);
         end
      end

      // lw with mem_ready low three cycles in MEM_RD
      run_instr(OP_LW, 6'h00, 1'b0, 1'b0, 0, 3);
      check(obs.size() == 8 && obs[7].m2r === 1'b1 && obs[7].rw === 1'b1 && obs[6].mr === 1'b1,
            "lw_wait3_latency", obs.size(), 8);

      // undefined opcode traps, illegal sticky, cleared by a one-cycle reset
      run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0);
      check(obs.size() == 5 && obs[4].ill === 1'b1, "opcode3f_trap", obs.size(), 5);
      run_instr(OP_R, 6'h20, 1'b0, 1'b0, 0, 0);
      check(obs[0].ill === 1'b0, "illegal_cleared", obs[0].ill, 0);

      // unknown funct traps after EXEC_R without a register write
      run_instr(OP_R, 6'h3E, 1'b0, 1'b0, 0, 0);
      check(obs[2].rw === 1'b0 && obs[3].ill === 1'b1, "bad_funct_trap", obs[3].ill, 1);

      // fetch timeout: stuck low traps after TMO cycles; ready on the limit cycle wins
      run_instr(OP_R, 6'h20, 1'b0, 1'b0, TMO + 2, 0);
      check(obs.size() == TMO + 3 && obs[TMO].ill === 1'b1, "fetch_timeout", obs.size(), TMO + 3);
      run_instr(OP_R, 6'h25, 1'b0, 1'b0, TMO - 1, 0);
      check(obs.size() == TMO + 3 && obs[TMO - 1].ir_w === 1'b1, "fetch_limit_ready_wins",
            obs.size(), TMO + 3);
      run_instr(OP_SW, 6'h00, 1'b0, 1'b0, 0, TMO);
      check(obs[3 + TMO].ill === 1'b1, "mem_wr_timeout", obs[3 + TMO].ill, 1);

      // reset in the middle of MEM_WR drops mem_write in the reset cycle
      begin
         out_t e;
         obs.delete();
         e = '0; e.mr = 1'b1; e.src_b = 2'b01; e.ir_w = 1'b1; e.pc_w = 1'b1;
         cyc(e, m_all, 1'b1, r6(), r6(), 1'b0, 1'b0, "rstwr_fetch");
         e = '0; e.src_b = 2'b10;
         cyc(e, m_all, 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, "rstwr_decode");
         e = '0; e.src_a = 1'b1; e.src_b = 2'b10;
         cyc(e, m_all, 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, "rstwr_addr");
         e = '0; e.mw = 1'b1;
         cyc(e, m_all, 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, "rstwr_memwr");
         do_reset();
         run_instr(OP_ADDI, 6'h00, 1'b0, 1'b0, 0, 0);
      end

      // randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         op = ($urandom_range(0, 9) == 0) ? r6() : legal_ops[$urandom_range(0, 13)];
         fn = ($urandom_range(0, 7) == 0) ? r6() : legal_fn[$urandom_range(0, 9)];
         fw = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, TMO - 1);
         mw = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, TMO - 1);
         run_instr(op, fn, rb(), rb(), fw, mw);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
